handshake_datagram_receiver: RTL and testbench
==============================================

# handshake_datagram_receiver

Receiving end of the four-phase REQ/ACK link that the central board drives to each display board. It synchronises the incoming REQ into the local clock domain, captures one 6-bit chunk per handshake, returns ACK, and reassembles chunks into a full MESSAGE_SIZE datagram. The output is a registered datagram plus a one-cycle valid pulse, feeding the local output_interface. One instance sits on each display board.

## Interface
- N, default MESSAGE_SIZE (shared package), datagram width in bits
- CHUNK_W, default 6, bits per handshake; matches DOUT width
- SYNC_STAGES, default 2, flip-flops in the REQ synchroniser (≥2)
- GAP_CYCLES, default 1024, idle clk cycles mid-frame before the chunk counter is discarded
- clk  input  1  board clock; all logic on posedge
- rst  input  1  synchronous, active-low reset
- REQ  input  1  request from the transmitter, asynchronous to clk
- DIN  input  CHUNK_W  chunk data; stable from before REQ rises until ACK is seen
- ACK  output  1  registered acknowledge to the transmitter
- datagram  output  N  last complete datagram, held until the next one completes
- datagram_valid  output  1  one-cycle pulse when datagram updates
- frame_err  output  1  one-cycle pulse when a partial frame is dropped by the gap timeout

## Operation
- NUM_CHUNKS = ceil(N / CHUNK_W). Chunks arrive most-significant first. The first chunk carries bits [N-1 : (NUM_CHUNKS-1)*CHUNK_W] in its low bits; unused upper bits are ignored.
- REQ passes through a SYNC_STAGES flip-flop chain to produce req_s. DIN is not synchronised: it is bundled data, so it is sampled only when req_s=1.
- FSM states:
  - IDLE: ACK=0. When req_s=1, register DIN into the shift register at chunk_idx and go to HOLD. Detection is level-based, so a REQ still high after reset is accepted as a fresh chunk.
  - HOLD: ACK=1. Wait for req_s=0, then go to IDLE with ACK=0 on the next registered update.
- Capture of the chunk with chunk_idx = NUM_CHUNKS-1:
  - datagram is loaded with the assembled value and datagram_valid pulses in the same cycle.
  - chunk_idx wraps to 0.
  - Otherwise chunk_idx increments.
- Gap timer: counts clk cycles while in IDLE with chunk_idx≠0; cleared on each capture.
  - At GAP_CYCLES: chunk_idx←0, the partial shift register is discarded, and frame_err pulses once. datagram is unchanged.
- Simultaneous gap expiry and req_s=1 in IDLE: the timeout wins for that cycle. The chunk is captured next cycle as chunk 0.
- Reset values: ACK=0, datagram=0, datagram_valid=0, frame_err=0, state IDLE, chunk_idx=0, gap timer=0, synchroniser flops=0. Reset mid-handshake drops ACK; the transmitter's pending chunk is re-accepted as chunk 0.

## Timing
- REQ pin rise to ACK high: SYNC_STAGES+1 clk cycles (3 at default).
- REQ pin fall to ACK low: SYNC_STAGES+1 clk cycles.
- Minimum handshake period, measured at receiver: 2·(SYNC_STAGES+1) cycles plus the transmitter's own synchroniser latency.
- datagram_valid asserts in the same cycle ACK rises for the final chunk; datagram is valid from that cycle.
- No back-pressure from the consumer: a new datagram overwrites the held one.

## Structure
- Shared package (constants.svh / typedefs.svh): MESSAGE_SIZE, CHUNK_W, NUM_CHUNKS, and the FSM state enum (IDLE, HOLD).
- One sub-module: req_synchronizer, a parameterised SYNC_STAGES flop chain with active-low synchronous reset. It is reused by the transmitter's ACK path.
- The chunk counter, gap timer and shift register live in the top of the block.

## Test plan
- Reset with REQ=0 → ACK=0, datagram=0, no pulses. Release reset, drive 4 idle cycles → outputs stay 0.
- N=24, send chunks 0x3F,0x00,0x2A,0x15 with a full four-phase handshake each → datagram=0xFC0A95, with one datagram_valid pulse coinciding with the 4th ACK rise.
- Each handshake → ACK rises exactly 3 cycles after REQ rises and falls 3 cycles after REQ falls; DIN changed while REQ=0 has no effect.
- Send 2 chunks, hold REQ low for GAP_CYCLES → frame_err pulses once, datagram unchanged. Then send a full 4-chunk frame → correct datagram.
- Assert rst mid-frame while ACK=1 and REQ held high → ACK=0 during reset. After release, ACK rises 3 cycles later and that chunk lands as chunk 0.
- N=20 (partial top chunk), first chunk 0x3F → only the low 2 bits are used; datagram[19:18]=2'b11, upper padding ignored.

Source files
------------

// File: rtl/handshake_datagram_receiver_pkg.sv
// Shared constants and types for the REQ/ACK datagram link.
// Used by both ends of the link so chunk sizing always agrees.
package handshake_datagram_receiver_pkg;

  localparam int MESSAGE_SIZE = 24;
  localparam int CHUNK_W      = 6;

  function automatic int calc_num_chunks(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

  localparam int NUM_CHUNKS = calc_num_chunks(MESSAGE_SIZE, CHUNK_W);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/handshake_datagram_receiver_req_sync.sv
// Multi-flop synchroniser for a single asynchronous level (REQ or ACK).
// Synchronous active-low reset clears the whole chain.
module req_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/handshake_datagram_receiver.sv
// Receiving end of the four-phase REQ/ACK chunk link: captures one chunk per
// handshake, reassembles MSB-first into an N-bit datagram, drops stale frames.
module handshake_datagram_receiver
  import handshake_datagram_receiver_pkg::*;
#(
  parameter int N           = handshake_datagram_receiver_pkg::MESSAGE_SIZE,
  parameter int CHUNK_W     = handshake_datagram_receiver_pkg::CHUNK_W,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req,
  input  logic [CHUNK_W-1:0] i_din,
  output logic               o_ack,
  output logic [N-1:0]       o_datagram,
  output logic               o_datagram_valid,
  output logic               o_frame_err
);

  localparam int NCH   = calc_num_chunks(N, CHUNK_W);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic             w_req_s;
  logic [N-1:0]     w_shift_next;
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [GAP_W-1:0] r_gap;
  logic [N-1:0]     r_shift;

  req_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_req),
    .o_sync  (w_req_s)
  );

  // Slot gi holds chunk NCH-1-gi; the top slot may be narrower than CHUNK_W.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
      localparam int LO = gi * CHUNK_W;
      localparam int HI = (LO + CHUNK_W > N) ? N - 1 : LO + CHUNK_W - 1;
      assign w_shift_next[HI:LO] = (r_idx == IDX_W'(NCH - 1 - gi)) ?
                                   i_din[HI-LO:0] : r_shift[HI:LO];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state          <= IDLE;
      r_idx            <= '0;
      r_gap            <= '0;
      r_shift          <= '0;
      o_ack            <= 1'b0;
      o_datagram       <= '0;
      o_datagram_valid <= 1'b0;
      o_frame_err      <= 1'b0;
    end else begin
      o_datagram_valid <= 1'b0;
      o_frame_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          // A timeout takes priority; a pending REQ is then taken as chunk 0.
          if (r_idx != '0 && r_gap == GAP_LAST) begin
            r_idx       <= '0;
            r_gap       <= '0;
            r_shift     <= '0;
            o_frame_err <= 1'b1;
          end else if (w_req_s) begin
            r_shift <= w_shift_next;
            r_gap   <= '0;
            r_state <= HOLD;
            o_ack   <= 1'b1;
            if (r_idx == LAST_IDX) begin
              r_idx            <= '0;
              o_datagram       <= w_shift_next;
              o_datagram_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if (r_idx != '0) begin
            r_gap <= r_gap + 1'b1;
          end
        end
        HOLD: begin
          if (!w_req_s) begin
            r_state <= IDLE;
            o_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          o_ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_datagram_receiver.sv
// Directed + randomized bench for handshake_datagram_receiver (N=24 and N=20 instances
// sharing one REQ/DIN link), checked against a chunk-queue reference model.
module tb_handshake_datagram_receiver;

  localparam int GAP = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [5:0]  din;
  logic        ack_a, ack_b, dv_a, dv_b, fe_a, fe_b;
  logic [23:0] dg_a;
  logic [19:0] dg_b;

  int checks = 0;
  int passed = 0;
  int nvalid_a = 0, nvalid_b = 0, nferr_a = 0, nferr_b = 0;

  logic [5:0]  frame_q[$];
  logic [31:0] exp_a = 0;
  logic [31:0] exp_b = 0;

  always #5 clk = ~clk;

  handshake_datagram_receiver #(.N(24), .CHUNK_W(6), .SYNC_STAGES(2), .GAP_CYCLES(GAP)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_din(din),
    .o_ack(ack_a), .o_datagram(dg_a), .o_datagram_valid(dv_a), .o_frame_err(fe_a)
  );

  handshake_datagram_receiver #(.N(20), .CHUNK_W(6), .SYNC_STAGES(2), .GAP_CYCLES(GAP)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_din(din),
    .o_ack(ack_b), .o_datagram(dg_b), .o_datagram_valid(dv_b), .o_frame_err(fe_b)
  );

  always @(negedge clk) begin
    if (dv_a) nvalid_a++;
    if (dv_b) nvalid_b++;
    if (fe_a) nferr_a++;
    if (fe_b) nferr_b++;
  end

  // Reference: datagram = MSB-first concatenation of the frame's chunks, truncated to n bits.
  function automatic logic [31:0] fold(input int n);
    logic [31:0] acc;
    acc = 0;
    foreach (frame_q[i]) acc = (acc << 6) | 32'(frame_q[i]);
    return acc & ((32'd1 << n) - 32'd1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic send_chunk(input logic [5:0] d);
    int  k;
    bit  last;
    last = (frame_q.size() == 3);
    din  = d;
    req  = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!ack_a && k < 20);
    check("ack_rise_latency", k, 3);
    check("ack_b_high", ack_b, 1);
    check("valid_a_at_ack", dv_a, last);
    check("valid_b_at_ack", dv_b, last);
    frame_q.push_back(d);
    if (last) begin
      exp_a = fold(24);
      exp_b = fold(20);
      frame_q.delete();
    end
    check("datagram_a", dg_a, exp_a);
    check("datagram_b", dg_b, exp_b);
    req = 1'b0;
    din = 6'($urandom);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (ack_a && k < 20);
    check("ack_fall_latency", k, 3);
    // Idle gap with DIN wiggling while REQ is low
    repeat ($urandom_range(0, 4)) begin
      din = 6'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [5:0] c0, c1, c2, c3);
    int nv_a, nv_b;
    nv_a = nvalid_a;
    nv_b = nvalid_b;
    send_chunk(c0);
    send_chunk(c1);
    send_chunk(c2);
    send_chunk(c3);
    check("valid_pulses_a", nvalid_a - nv_a, 1);
    check("valid_pulses_b", nvalid_b - nv_b, 1);
    $display("frame %02h %02h %02h %02h -> a=0x%06h b=0x%05h", c0, c1, c2, c3, dg_a, dg_b);
  endtask

  initial begin
    int k, nf_a, nf_b, nv_a;
    logic [23:0] hold_a;
    logic [19:0] hold_b;
    logic [5:0]  pend;

    rst_n = 1'b0;
    req   = 1'b0;
    din   = '0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_ack", ack_a, 0);
    check("reset_datagram_a", dg_a, 0);
    check("reset_datagram_b", dg_b, 0);
    check("reset_valid", dv_a, 0);
    check("reset_ferr", fe_a, 0);

    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("idle_outputs", {ack_a, dv_a, fe_a, dg_a}, 0);
    end

    // Directed frame from the example
    send_frame(6'h3F, 6'h00, 6'h2A, 6'h15);
    check("directed_24", dg_a, 24'hFC0A95);
    check("partial_top_bits", dg_b[19:18], 2'b11);
    check("directed_20", dg_b, 20'hC0A95);

    // Randomized frames
    repeat (4) send_frame(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));

    // Gap timeout drops a partial frame
    nf_a = nferr_a;
    nf_b = nferr_b;
    nv_a = nvalid_a;
    hold_a = dg_a;
    hold_b = dg_b;
    send_chunk(6'($urandom));
    send_chunk(6'($urandom));
    repeat (GAP + 20) @(posedge clk);
    #1;
    frame_q.delete();
    check("gap_ferr_a", nferr_a - nf_a, 1);
    check("gap_ferr_b", nferr_b - nf_b, 1);
    check("gap_datagram_a", dg_a, hold_a);
    check("gap_datagram_b", dg_b, hold_b);
    check("gap_no_valid", nvalid_a - nv_a, 0);
    $display("gap timeout: frame_err pulses a=%0d b=%0d", nferr_a - nf_a, nferr_b - nf_b);
    send_frame(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));

    // Reset mid-frame while ACK is high and REQ stays high
    send_chunk(6'($urandom));
    send_chunk(6'($urandom));
    pend = 6'($urandom);
    din = pend;
    req = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!ack_a && k < 20);
    check("pre_reset_ack", ack_a, 1);
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("ack_in_reset", ack_a, 0);
    end
    check("datagram_after_reset", dg_a, 0);
    frame_q.delete();
    exp_a = 0;
    exp_b = 0;
    rst_n = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!ack_a && k < 20);
    check("post_reset_ack_latency", k, 3);
    check("post_reset_no_valid", dv_a, 0);
    frame_q.push_back(pend);
    req = 1'b0;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (ack_a && k < 20);
    check("post_reset_ack_fall", k, 3);
    send_chunk(6'($urandom));
    send_chunk(6'($urandom));
    send_chunk(6'($urandom));
    check("reset_frame_datagram_a", dg_a, exp_a);
    $display("post-reset frame -> a=0x%06h b=0x%05h", dg_a, dg_b);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
